// File: rtl/edabk_uart_pkg.sv
// Shared UART definitions for the transmit engine and the future receiver engine.
//   uart_tx_state_t : frame sequencing states
//   PAR_*           : cfg_parity encodings (2'b11 is reserved and behaves as none)
package edabk_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/edabk_uart_tx_engine_if.sv
// Host-to-engine word handshake.
//   tx_valid : word offered by the host
//   tx_ready : engine can accept a word this cycle
//   tx_data  : word to send (sampled only in the accept cycle)
// master = host side (TX buffer), slave = transmit engine.
interface edabk_uart_tx_engine_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/edabk_uart_bit_timer.sv
// Bit-period timer shared by the UART transmit and receive engines.
//   bclk, reset_n : baud clock, asynchronous active-low reset
//   restart       : synchronous clear of the divider (start of a new frame)
//   enable        : count while a frame is in progress
//   bit_end       : high in the last bclk cycle of each bit period
module edabk_uart_bit_timer #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic bclk,
  input  logic reset_n,
  input  logic restart,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (restart) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (div_cnt == CNT_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bit_end = enable & (div_cnt == CNT_LAST);

endmodule

// File: rtl/edabk_uart_tx_engine.sv
// Self-timed UART transmit engine: accepts a word over the valid/ready
// handshake and sends start, DATA_WIDTH data bits LSB first, optional parity,
// and one or two stop bits on tx. Each bit lasts CLK_DIV bclk cycles.
//   bclk, reset_n : baud clock, asynchronous active-low reset
//   tx_if         : word handshake (slave side)
//   cfg_parity    : 00 none, 01 even, 10 odd, 11 none (captured on accept)
//   cfg_stop2     : 0 one stop bit, 1 two stop bits (captured on accept)
//   tx            : registered serial line, idles high
//   busy          : frame in progress
//   finish        : one-cycle pulse in the last cycle of a frame
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif

module edabk_uart_tx_engine
  import edabk_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `CFG_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = `CFG_CLK_DIV
) (
  input  logic                         bclk,
  input  logic                         reset_n,
  edabk_uart_tx_engine_if.slave        tx_if,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop2,
  output logic                         tx,
  output logic                         busy,
  output logic                         finish
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);

  uart_tx_state_t        state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  par_en;
  logic                  par_bit;
  logic                  stop2;
  logic                  tx_q;
  logic                  bit_end;
  logic                  last_stop;
  logic                  accept;

  edabk_uart_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .bclk    (bclk),
    .reset_n (reset_n),
    .restart (accept),
    .enable  (state != IDLE),
    .bit_end (bit_end)
  );

  // In STOP, bit_cnt counts stop bits already sent.
  assign last_stop      = (bit_cnt == {{(BIT_W-1){1'b0}}, stop2});
  assign finish         = (state == STOP) & last_stop & bit_end;
  assign tx_if.tx_ready = (state == IDLE) | finish;
  assign accept         = tx_if.tx_valid & tx_if.tx_ready;
  assign busy           = (state != IDLE);
  assign tx             = tx_q;

  // tx is loaded with the value of the next bit at the same edge the state
  // advances, so the line changes exactly on bit boundaries.
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      tx_q      <= 1'b1;
    end else if (accept) begin
      state     <= START;
      shift_reg <= tx_if.tx_data;
      bit_cnt   <= '0;
      par_en    <= (cfg_parity == PAR_EVEN) | (cfg_parity == PAR_ODD);
      par_bit   <= (^tx_if.tx_data) ^ (cfg_parity == PAR_ODD);
      stop2     <= cfg_stop2;
      tx_q      <= 1'b0;
    end else if (bit_end) begin
      case (state)
        START: begin
          state <= DATA;
          tx_q  <= shift_reg[0];
        end
        DATA: begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt <= '0;
            if (par_en) begin
              state <= PARITY;
              tx_q  <= par_bit;
            end else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= shift_reg >> 1;
            tx_q      <= shift_reg[1];
          end
        end
        PARITY: begin
          state <= STOP;
          tx_q  <= 1'b1;
        end
        STOP: begin
          if (last_stop) state   <= IDLE;
          else           bit_cnt <= bit_cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
